// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: FSM state encoding,
// source count and default per-source exception vectors.
package intr_ctrl_pkg;

    // Only four sources are supported by the priority selector.
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;

    localparam logic [31:0] VEC0_DEF = 32'h0000_002c;
    localparam logic [31:0] VEC1_DEF = 32'h0000_0004;
    localparam logic [31:0] VEC2_DEF = 32'h0000_0008;
    localparam logic [31:0] VEC3_DEF = 32'h0000_000c;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StService = 2'b10
    } state_t;

endpackage

// File: rtl/intr_prio_sel.sv
// Fixed-priority winner selection over the candidate set (pending & ~mask).
// Source 0 has the highest priority. Purely combinational.
module intr_prio_sel
    import intr_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC0 = VEC0_DEF,
    parameter logic [31:0] VEC1 = VEC1_DEF,
    parameter logic [31:0] VEC2 = VEC2_DEF,
    parameter logic [31:0] VEC3 = VEC3_DEF
) (
    input  logic [NUM_SRC-1:0] cand,
    output logic               valid,
    output logic [ID_W-1:0]    id,
    output logic [31:0]        vec
);

    // Lowest set index wins; outputs are zero when nothing is a candidate.
    always_comb begin
        valid = 1'b1;
        id    = '0;
        vec   = '0;
        if (cand[0]) begin
            id  = 2'd0;
            vec = VEC0;
        end else if (cand[1]) begin
            id  = 2'd1;
            vec = VEC1;
        end else if (cand[2]) begin
            id  = 2'd2;
            vec = VEC2;
        end else if (cand[3]) begin
            id  = 2'd3;
            vec = VEC3;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: rising-edge event capture into pending bits,
// maskable fixed-priority selection, and an IDLE/REQ/SERVICE handshake with the CPU.
// Optional feature: define INTR_CTRL_ACK_TIMEOUT_EN to abandon a request that is not
// acknowledged within ACK_TIMEOUT cycles (sets sticky timeout_err, keeps pending).
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = intr_ctrl_pkg::NUM_SRC,
    parameter logic [31:0] VEC0        = VEC0_DEF,
    parameter logic [31:0] VEC1        = VEC1_DEF,
    parameter logic [31:0] VEC2        = VEC2_DEF,
    parameter logic [31:0] VEC3        = VEC3_DEF,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] done,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic               irq,
    input  logic               irq_ack,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        EAddr,
    input  logic               eoi,
    output logic               busy,
    output logic               timeout_err
);

    if (NUM_SRC != 4 || ACK_TIMEOUT == 0) begin : g_bad_param
        $error("intr_ctrl: NUM_SRC must be 4 and ACK_TIMEOUT non-zero");
    end

    state_t             state_q;
    logic [NUM_SRC-1:0] done_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] cand;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [31:0]        win_vec;
    logic               timeout_hit;

    assign rise = done & ~done_prev_q;
    assign cand = pending_q & ~mask;

    // Ack clears the serviced source; a same-cycle new edge re-sets it.
    always_comb begin
        ack_clr = '0;
        if (state_q == StReq && irq_ack) begin
            ack_clr[irq_id] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr) | rise;
    end

    // Event history, pending bits and mask register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_prev_q <= '0;
            pending_q   <= '0;
            mask        <= '0;
        end else begin
            done_prev_q <= done;
            pending_q   <= pending_d;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    intr_prio_sel #(
        .VEC0 (VEC0),
        .VEC1 (VEC1),
        .VEC2 (VEC2),
        .VEC3 (VEC3)
    ) u_prio_sel (
        .cand  (cand),
        .valid (win_valid),
        .id    (win_id),
        .vec   (win_vec)
    );

`ifdef INTR_CTRL_ACK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == StReq) && !irq_ack &&
                         (cnt_q == CntW'(ACK_TIMEOUT - 1));
    assign timeout_err = err_q;

    // Count unacknowledged REQ cycles; sticky error once the budget is spent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StReq && !irq_ack && !timeout_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Request/service FSM; irq, busy, irq_id and EAddr are registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            irq     <= 1'b0;
            busy    <= 1'b0;
            irq_id  <= '0;
            EAddr   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StReq;
                        irq     <= 1'b1;
                        irq_id  <= win_id;
                        EAddr   <= win_vec;
                    end
                end
                StReq: begin
                    if (irq_ack) begin
                        state_q <= StService;
                        irq     <= 1'b0;
                        busy    <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= StIdle;
                        irq     <= 1'b0;
                        irq_id  <= '0;
                        EAddr   <= '0;
                    end
                end
                StService: begin
                    if (eoi) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        irq_id  <= '0;
                        EAddr   <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    irq     <= 1'b0;
                    busy    <= 1'b0;
                    irq_id  <= '0;
                    EAddr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expected (id, vector) pairs are queued when events
// are driven and popped when the controller raises irq.
module tb_intr_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  done;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [3:0]  mask;
    logic        irq;
    logic        irq_ack;
    logic [1:0]  irq_id;
    logic [31:0] EAddr;
    logic        eoi;
    logic        busy;
    logic        timeout_err;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   vectors;
    int   miscompares;

    intr_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .mask        (mask),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .irq_id      (irq_id),
        .EAddr       (EAddr),
        .eoi         (eoi),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for irq, then compare id/vector against the scoreboard head.
    task automatic expect_req(input string tag);
        int cyc;
        cyc = 0;
        while (irq !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_irq"}, {31'd0, irq}, 32'd1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb: observed request, expected none queued", tag);
            cur.id  = 2'd0;
            cur.vec = 32'd0;
        end else begin
            cur = exp_q.pop_front();
            check({tag, "_id"}, {30'd0, irq_id}, {30'd0, cur.id});
            check({tag, "_vec"}, EAddr, cur.vec);
        end
    endtask

    // Acknowledge the current request, check the service state, then end it.
    task automatic serve(input string tag);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_svc_irq"}, {31'd0, irq}, 32'd0);
        check({tag, "_svc_vec"}, EAddr, cur.vec);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_vec"}, EAddr, 32'd0);
        check({tag, "_idle_id"}, {30'd0, irq_id}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_id"}, {30'd0, irq_id}, 32'd0);
        check({tag, "_vec"}, EAddr, 32'd0);
        check({tag, "_mask"}, {28'd0, mask}, 32'd0);
        check({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        done        = 4'h0;
        mask_we     = 1'b0;
        mask_wdata  = 4'h0;
        irq_ack     = 1'b0;
        eoi         = 1'b0;

        // Reset state
        tick(2);
        check_zero("reset");
        rst = 1'b1;
        tick(2);
        check("post_reset_irq", {31'd0, irq}, 32'd0);

        // Single pulse on source 1, exact two-cycle latency
        done = 4'b0010;
        push(2'd1, 32'h0000_0004);
        tick(1);
        done = 4'b0000;
        check("lat_c1_irq", {31'd0, irq}, 32'd0);
        tick(1);
        check("lat_c2_irq", {31'd0, irq}, 32'd1);
        expect_req("src1");
`ifdef INTR_CTRL_ACK_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            while (irq === 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("tmo_cycles", cyc, 32'd16);
            check("tmo_err", {31'd0, timeout_err}, 32'd1);
            push(2'd1, 32'h0000_0004);
            expect_req("tmo_rereq");
        end
`else
        tick(20);
        check("noto_irq", {31'd0, irq}, 32'd1);
        check("noto_id", {30'd0, irq_id}, 32'd1);
        check("noto_terr", {31'd0, timeout_err}, 32'd0);
`endif
        serve("src1");

        // Simultaneous events: source 0 before source 3
        done = 4'b1001;
        push(2'd0, 32'h0000_002c);
        push(2'd3, 32'h0000_000c);
        tick(1);
        done = 4'b0000;
        expect_req("both_0");
        serve("both_0");
        expect_req("both_3");
        serve("both_3");

        // Masked source stays pending until unmasked
        mask_we    = 1'b1;
        mask_wdata = 4'b0001;
        tick(1);
        mask_we = 1'b0;
        check("mask_rd", {28'd0, mask}, 32'h1);
        done = 4'b0001;
        tick(1);
        done = 4'b0000;
        tick(5);
        check("masked_irq", {31'd0, irq}, 32'd0);
        push(2'd0, 32'h0000_002c);
        mask_we    = 1'b1;
        mask_wdata = 4'b0000;
        tick(1);
        mask_we = 1'b0;
        check("unmask_c1_irq", {31'd0, irq}, 32'd0);
        tick(1);
        check("unmask_c2_irq", {31'd0, irq}, 32'd1);
        expect_req("unmask");
        serve("unmask");

        // No pre-emption; masking does not withdraw an active request
        done = 4'b0100;
        push(2'd2, 32'h0000_0008);
        tick(1);
        done = 4'b0000;
        expect_req("src2");
        done = 4'b0001;
        push(2'd0, 32'h0000_002c);
        mask_we    = 1'b1;
        mask_wdata = 4'b0100;
        tick(1);
        done    = 4'b0000;
        mask_we = 1'b0;
        tick(2);
        check("frozen_irq", {31'd0, irq}, 32'd1);
        check("frozen_id", {30'd0, irq_id}, 32'd2);
        check("frozen_vec", EAddr, 32'h0000_0008);
        serve("src2");
        expect_req("after_src2");
        serve("after_src2");

        // New edge on the source being acknowledged keeps it pending
        done = 4'b0010;
        push(2'd1, 32'h0000_0004);
        tick(1);
        done = 4'b0000;
        expect_req("clr_race");
        done = 4'b0010;
        push(2'd1, 32'h0000_0004);
        serve("clr_race");
        done = 4'b0000;
        expect_req("clr_race_again");
        serve("clr_race_again");

        // Asynchronous reset during service, source held high across release
        mask_we    = 1'b1;
        mask_wdata = 4'b0100;
        done       = 4'b1000;
        push(2'd3, 32'h0000_000c);
        tick(1);
        mask_we = 1'b0;
        expect_req("pre_rst");
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        tick(2);
        rst = 1'b1;
        push(2'd3, 32'h0000_000c);
        expect_req("held_src");
        serve("held_src");
        tick(6);
        check("held_no_retrig", {31'd0, irq}, 32'd0);
        check("held_sb_empty", exp_q.size(), 32'd0);
        done = 4'b0000;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
